// File: rtl/graytobin_seq.sv
// Sequential Gray-to-binary decoder, one bit per clock, MSB first.
// Flags accepted words that are not 1-bit-adjacent to the previous one.
module graytobin_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             adj_err
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] acc_sh;
  logic [IW-1:0]    idx_q;
  logic             have_prev_q;
  logic             err_q;
  logic             adj_q;
  logic             err_d;
  logic             accept;
  logic             last;

  assign accept = (state_q == IDLE) & in_valid;
  assign last   = (state_q == CONV) & (idx_q == '0);

  // State register; reset discards any in-flight word
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = CONV;
      CONV:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Resolve bit idx from the bit above it; the MSB sees a zero above
  always_comb begin
    acc_sh = acc_q >> 1;
    acc_d  = acc_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (IW'(i) == idx_q) acc_d[i] = g_q[i] ^ acc_sh[i];
    end
  end

  // Adjacent iff the XOR difference has exactly one bit set
  always_comb begin
    diff  = gray_in ^ prev_q;
    err_d = have_prev_q &
            ~((diff != '0) & ((diff & (diff - 1'b1)) == '0));
  end

  // Datapath registers: capture, bit-serial accumulate, result hold
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
      bin_q       <= '0;
      adj_q       <= 1'b0;
    end else if (accept) begin
      g_q         <= gray_in;
      acc_q       <= '0;
      idx_q       <= IW'(WIDTH - 1);
      prev_q      <= gray_in;
      have_prev_q <= 1'b1;
      err_q       <= err_d;
    end else if (state_q == CONV) begin
      acc_q <= acc_d;
      idx_q <= idx_q - 1'b1;
      if (last) begin
        bin_q <= acc_d;
        adj_q <= err_q;
      end
    end
  end

  assign bin_out = bin_q;
  assign adj_err = adj_q;

endmodule

// File: tb/tb_graytobin_seq.sv
// Directed bench for graytobin_seq (WIDTH=4).
// Drives and samples 1 time unit after each rising edge.
module tb_graytobin_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] gray_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] bin_out;
  logic         adj_err;

  int checks = 0;
  int errs   = 0;

  graytobin_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .adj_err   (adj_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  // Send one word, expect result; hold out_ready low for 'hold' cycles
  task automatic do_word(input string tag, input logic [W-1:0] g,
                         input logic [W-1:0] eb, input logic ee,
                         input int hold);
    int n;
    logic [W-1:0] b0;
    logic e0;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    gray_in   = g;
    step();
    in_valid = 1'b0;
    wait_out(n);
    chk({tag, ".latency"}, 32'(n), 32'd4);
    chk({tag, ".bin"}, 32'(bin_out), 32'(eb));
    chk({tag, ".adj"}, 32'(adj_err), 32'(ee));
    b0 = bin_out;
    e0 = adj_err;
    for (int k = 0; k < hold; k++) begin
      step();
      chk({tag, ".hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_b"}, 32'(bin_out), 32'(b0));
      chk({tag, ".hold_e"}, 32'(adj_err), 32'(e0));
      chk({tag, ".hold_r"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk({tag, ".idle_r"}, 32'(in_ready), 32'd1);
    chk({tag, ".idle_v"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] gi;
    rst       = 1'b1;
    in_valid  = 1'b0;
    gray_in   = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.bin", 32'(bin_out), 32'd0);
    chk("rst.adj", 32'(adj_err), 32'd0);

    do_word("T1", 4'b0110, 4'b0100, 1'b0, 0);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      gi = W'(i) ^ (W'(i) >> 1);
      do_word($sformatf("T2.%0d", i), gi, W'(i), 1'b0, 0);
    end

    do_word("T3a", 4'b1111, 4'b1010, 1'b1, 0);
    do_word("T3b", 4'b1000, 4'b1111, 1'b1, 0);

    do_reset();
    do_word("T4a", 4'b0000, 4'b0000, 1'b0, 0);
    do_word("T4b", 4'b0011, 4'b0010, 1'b1, 0);
    do_word("T4c", 4'b0011, 4'b0010, 1'b1, 0);
    do_word("T4d", 4'b0111, 4'b0101, 1'b0, 0);

    do_word("T5", 4'b0101, 4'b0110, 1'b0, 5);

    in_valid = 1'b1;
    gray_in  = 4'b1100;
    step();
    in_valid = 1'b0;
    chk("T6.busy", 32'(in_ready), 32'd0);
    step();
    step();
    do_reset();
    chk("T6.in_ready", 32'(in_ready), 32'd1);
    chk("T6.out_valid", 32'(out_valid), 32'd0);
    chk("T6.bin", 32'(bin_out), 32'd0);
    do_word("T6n", 4'b0001, 4'b0001, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
